// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx; define UART_ARB_TIMEOUT_EN for the WAIT timeout and sticky err_timeout
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                       err_timeout
`endif
);
  localparam int IW = $clog2(N_REQ);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t state;
  logic [GW-1:0] gap_cnt;
  logic hit;
  logic [IW-1:0] win, cand;
  logic [DATA_W-1:0] win_data;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`endif
  if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end
  always_comb begin
    hit = 1'b0;
    win = grant_id;
    cand = '0;
    win_data = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(grant_id) + k) % N_REQ);
      if (!hit && req_valid[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
    for (int i = 0; i < N_REQ; i++)
      if (IW'(i) == win) win_data = req_data[i*DATA_W +: DATA_W];
    req_ready = (state == IDLE && hit) ? N_REQ'(1) << win : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx_start <= 1'b0;
      tx_data <= '0;
      busy <= 1'b0;
      grant_id <= IW'(N_REQ - 1);
      gap_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (hit) begin
          tx_data <= win_data;
          grant_id <= win;
          tx_start <= 1'b1;
          busy <= 1'b1;
          state <= START;
        end
        START: begin
          state <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: if (tx_done) begin
          state <= GAP_CYCLES == 0 ? IDLE : GAP;
          busy <= GAP_CYCLES != 0;
          gap_cnt <= GW'(GAP_CYCLES - 1);
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
          err_timeout <= 1'b1;
        end else wait_cnt <= wait_cnt + 1'b1;
`endif
        GAP: if (gap_cnt == '0) begin
          state <= IDLE;
          busy <= 1'b0;
        end else gap_cnt <= gap_cnt - 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench against a cycle-timeline reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, GAP = 2, TO = 16;
  logic clk = 0, rst = 1, tx_done = 0;
  logic [N-1:0] v = '0;
  logic [N*W-1:0] d = '0;
  logic [N-1:0] req_ready;
  logic tx_start, busy;
  logic [W-1:0] tx_data;
  logic [1:0] grant_id;
`ifdef UART_ARB_TIMEOUT_EN
  logic err_timeout;
`endif
  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst), .req_valid(v), .req_data(d), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .grant_id(grant_id)
`ifdef UART_ARB_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, passed = 0, starts = 0;
  int ptr = N - 1, m_acc = -100, m_done = -1, last_done = -100, last_acc = -100, ucnt = 0;
  bit m_busy = 0, m_err = 0, chk = 0, st_prev = 0, rst_prev = 1, uart_en = 1, spur_en = 0;
  bit e_busy = 0, e_start = 0;
  logic [N-1:0] hs_last = '0, e_ready = '0;
  int qid[$], gq[$];
  logic [W-1:0] qdat[$];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask
  // reference model: arbiter timeline in cycle numbers, evaluated mid-cycle on the driven inputs
  always @(negedge clk) begin
    cyc++;
    hs_last = v & req_ready;
    st_prev = tx_start;
    rst_prev = rst;
    if (tx_done) last_done = cyc;
    if (hs_last != 0) last_acc = cyc;
    if (rst) begin
      m_busy = 0; m_err = 0; ptr = N - 1; chk = 0;
      qid.delete(); qdat.delete();
    end else begin
      chk = 1;
      if (m_busy && m_done >= 0 && cyc > m_done + GAP) m_busy = 0;
`ifdef UART_ARB_TIMEOUT_EN
      if (m_busy && m_done < 0 && cyc >= m_acc + 2 + TO) begin m_busy = 0; m_err = 1; end
`endif
      e_busy = m_busy;
      e_start = m_busy && cyc == m_acc + 1;
      e_ready = '0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (ptr + k) % N;
          if (v[j]) begin
            e_ready[j] = 1'b1; ptr = j; m_busy = 1; m_acc = cyc; m_done = -1;
            qid.push_back(j); qdat.push_back(d[j*W +: W]);
            break;
          end
        end
      end else if (m_done < 0 && tx_done && cyc >= m_acc + 2) m_done = cyc;
    end
  end
  always @(negedge clk) begin
    #1;
    if (chk) begin
      check("req_ready", req_ready, e_ready);
      check("busy", busy, e_busy);
      check("tx_start", tx_start, e_start);
`ifdef UART_ARB_TIMEOUT_EN
      check("err_timeout", err_timeout, m_err);
`endif
      if (tx_start) begin
        check("start_expected", qid.size() > 0, 1);
        if (qid.size() > 0) begin
          check("grant_id", grant_id, qid.pop_front());
          check("tx_data", tx_data, qdat.pop_front());
        end
      end
    end
    if (tx_start) begin starts++; gq.push_back(int'(grant_id)); end
  end
  // uart_tx stand-in: done 2..6 clocks into the frame, optional stray pulses when idle
  always @(posedge clk) begin
    #1;
    tx_done = 0;
    if (rst_prev) ucnt = 0;
    else if (st_prev) ucnt = $urandom_range(6, 2);
    else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0 && uart_en) tx_done = 1;
    end else if (spur_en && $urandom_range(7) == 0) tx_done = 1;
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); #2; endtask
  task automatic wait_accept();
    int n = 0;
    do begin tick(); n++; end while (hs_last == 0 && n < 200);
    check("accept_in_time", hs_last != 0, 1);
  endtask
  initial begin
    int acc, n, s0;
    repeat (3) tick();
    sample();
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_grant", grant_id, N - 1);
    check("rst_ready", req_ready, 0);
    tick();
    rst = 0;
    v = '1;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    gq.delete();
    acc = 0; n = 0;
    while (acc < 5 && n < 300) begin
      tick(); n++;
      if (hs_last != 0) begin
        acc++;
        for (int i = 0; i < N; i++) if (hs_last[i]) d[i*W +: W] = W'($urandom);
        if (acc == 5) v = '0;
      end
    end
    check("t1_accepts", acc, 5);
    repeat (20) tick();
    check("t1_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("t1_order", gq[i], i % N);
    v = 4'b0100; d[2*W +: W] = 8'hA5;
    wait_accept();
    check("t2_ready", hs_last, 4'b0100);
    v = '0;
    sample();
    check("t2_start", tx_start, 1);
    check("t2_data", tx_data, 8'hA5);
    tick();
    v = 4'b0100; d[2*W +: W] = 8'h5A;
    wait_accept();
    v = '0;
    check("t2_gap", last_acc - last_done - 1, GAP);
    repeat (20) tick();
    v = 4'b0001;
    wait_accept();
    v = '0;
    s0 = starts;
    tick();
    v = 4'b0010;
    tick();
    v = '0;
    repeat (30) tick();
    check("t5_starts", starts - s0, 1);
    check("t5_grant", grant_id, 0);
    v = 4'b0100;
    wait_accept();
    v = '0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    sample();
    check("t4_busy", busy, 0);
    check("t4_grant", grant_id, N - 1);
    check("t4_start", tx_start, 0);
    s0 = starts;
    repeat (10) tick();
    check("t4_no_start", starts - s0, 0);
    spur_en = 1;
    repeat (400) begin
      tick();
      for (int i = 0; i < N; i++)
        if (hs_last[i] || !v[i]) begin
          v[i] = $urandom_range(99) < 40;
          d[i*W +: W] = W'($urandom);
        end else if ($urandom_range(99) < 10) v[i] = 1'b0;
    end
    v = '0;
    spur_en = 0;
    repeat (30) tick();
`ifdef UART_ARB_TIMEOUT_EN
    uart_en = 0;
    v = 4'b0001;
    wait_accept();
    v = '0;
    repeat (25) tick();
    check("t6_err", err_timeout, 1);
    check("t6_idle", busy, 0);
    uart_en = 1;
    v = 4'b0010;
    wait_accept();
    check("t6_next", hs_last, 4'b0010);
    v = '0;
    repeat (20) tick();
    check("t6_sticky", err_timeout, 1);
`endif
    check("queue_empty", qid.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
